exec_phase_sequencer: RTL and testbench

//  Timing generator for the execute phase of a memory-reference instruction. On a start

---
 rtl/exec_phase_sequencer_pkg.sv | 16 +
 rtl/exec_phase_sequencer_if.sv | 26 ++
 rtl/exec_phase_sequencer.sv | 118 +++++++++++
 tb/tb_exec_phase_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_phase_sequencer_pkg.sv
// Shared definitions for the execute-phase sequencer: state encodings and step count.
package exec_phase_sequencer_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_PHA  = 2'd1,
    SEQ_PHB  = 2'd2
  } seq_state_e;

  localparam int NSTEPS_DEFAULT = 6;

  function automatic logic [2:0] last_step(input int nsteps);
    return 3'(nsteps - 1);
  endfunction

endpackage

// File: rtl/exec_phase_sequencer_if.sv
// Control/timing bundle between the execute-phase sequencer (master) and its decoder (slave).
interface exec_phase_sequencer_if
  import exec_phase_sequencer_pkg::*;
#(
  parameter int NSTEPS = NSTEPS_DEFAULT
);
  logic              start;
  logic              halt;
  logic              stall;
  logic              done;
  logic [NSTEPS-1:0] ck;
  logic [NSTEPS-1:0] stb;
  logic              busy;
  logic              finished;
  logic              overrun;

  modport master (
    input  start, halt, stall, done,
    output ck, stb, busy, finished, overrun
  );

  modport slave (
    output start, halt, stall, done,
    input  ck, stb, busy, finished, overrun
  );
endinterface

// File: rtl/exec_phase_sequencer.sv
// Execute-phase timing generator: one-hot step levels (ck) and mid-step strobes (stb),
// terminated by the decoder's done or flagged as overrun after the last step.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  SEQ_IDLE | no sequence; ck/stb zero, waiting for start with halt low
//  SEQ_PHA  | first half of step: ck[step] high, strobes low
//  SEQ_PHB  | second half of step: ck[step] and stb[step] high
module exec_phase_sequencer
  import exec_phase_sequencer_pkg::*;
#(
  parameter int NSTEPS = NSTEPS_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset,
  exec_phase_sequencer_if.master        seq
);

  localparam logic [2:0]        LAST_STEP = last_step(NSTEPS);
  localparam logic [NSTEPS-1:0] CK1       = NSTEPS'(1);

  seq_state_e        state_q, state_nxt;
  logic [2:0]        step_q, step_nxt;
  logic [NSTEPS-1:0] ck_q, ck_nxt;
  logic [NSTEPS-1:0] stb_q, stb_nxt;
  logic              busy_q, busy_nxt;
  logic              fin_q, fin_nxt;
  logic              ovr_q, ovr_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEQ_IDLE;
      step_q  <= '0;
      ck_q    <= '0;
      stb_q   <= '0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      step_q  <= step_nxt;
      ck_q    <= ck_nxt;
      stb_q   <= stb_nxt;
      busy_q  <= busy_nxt;
      fin_q   <= fin_nxt;
      ovr_q   <= ovr_nxt;
    end
  end

  // Outputs are computed one cycle ahead so every one of them comes straight off a flop;
  // holding the defaults is exactly the stall behaviour.
  always_comb begin
    state_nxt = state_q;
    step_nxt  = step_q;
    ck_nxt    = ck_q;
    stb_nxt   = stb_q;
    busy_nxt  = busy_q;
    fin_nxt   = 1'b0;
    ovr_nxt   = 1'b0;

    unique case (state_q)
      SEQ_IDLE: begin
        ck_nxt   = '0;
        stb_nxt  = '0;
        busy_nxt = 1'b0;
        step_nxt = '0;
        if (seq.start && !seq.halt) begin
          state_nxt = SEQ_PHA;
          ck_nxt    = CK1;
          busy_nxt  = 1'b1;
        end
      end

      SEQ_PHA, SEQ_PHB: begin
        if (seq.done) begin
          state_nxt = SEQ_IDLE;
          step_nxt  = '0;
          ck_nxt    = '0;
          stb_nxt   = '0;
          busy_nxt  = 1'b0;
          fin_nxt   = 1'b1;
        end else if (!seq.stall) begin
          if (state_q == SEQ_PHA) begin
            state_nxt = SEQ_PHB;
            stb_nxt   = CK1 << step_q;
          end else if (step_q == LAST_STEP) begin
            state_nxt = SEQ_IDLE;
            step_nxt  = '0;
            ck_nxt    = '0;
            stb_nxt   = '0;
            busy_nxt  = 1'b0;
            ovr_nxt   = 1'b1;
          end else begin
            state_nxt = SEQ_PHA;
            step_nxt  = step_q + 3'd1;
            ck_nxt    = CK1 << (step_q + 3'd1);
            stb_nxt   = '0;
          end
        end
      end

      default: begin
        state_nxt = SEQ_IDLE;
        step_nxt  = '0;
        ck_nxt    = '0;
        stb_nxt   = '0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  assign seq.ck       = ck_q;
  assign seq.stb      = stb_q;
  assign seq.busy     = busy_q;
  assign seq.finished = fin_q;
  assign seq.overrun  = ovr_q;

endmodule

// File: tb/tb_exec_phase_sequencer.sv
// Directed-vector bench for exec_phase_sequencer with NSTEPS = 6.
module tb_exec_phase_sequencer;
  import exec_phase_sequencer_pkg::*;

  localparam int N  = 6;
  localparam int NV = 21;

  typedef struct packed {
    logic         rst;
    logic         start;
    logic         halt;
    logic         stall;
    logic         done;
    logic [N-1:0] ck;
    logic [N-1:0] stb;
    logic         busy;
    logic         fin;
    logic         ovr;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  bit   armed = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   fin_at;
  int   ovr_at;
  int   busy_cnt;
  int   hold_cnt;
  int   cnt [N];
  vec_t vecs [NV];

  exec_phase_sequencer_if #(.NSTEPS(N)) bus ();

  exec_phase_sequencer #(.NSTEPS(N)) dut (
    .clk   (clk),
    .reset (reset),
    .seq   (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, input logic start, input logic halt,
                              input logic stall, input logic done, input logic [N-1:0] ck,
                              input logic [N-1:0] stb, input logic busy, input logic fin,
                              input logic ovr);
    vec_t v;
    v.rst = rst; v.start = start; v.halt = halt; v.stall = stall; v.done = done;
    v.ck = ck; v.stb = stb; v.busy = busy; v.fin = fin; v.ovr = ovr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.ck, bus.stb, bus.busy, bus.finished, bus.overrun});
  endfunction

  function automatic logic [31:0] pack_exp(input logic [N-1:0] ck, input logic [N-1:0] stb,
                                           input logic busy, input logic fin, input logic ovr);
    return 32'({ck, stb, busy, fin, ovr});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.start = 1'b0;
    bus.halt  = 1'b0;
    bus.stall = 1'b0;
    bus.done  = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Structural rules that must hold on every cycle.
  always @(negedge clk) begin
    if (armed) begin
      chk("inv_busy_eq_or_ck", 32'(bus.busy), 32'(|bus.ck));
      chk("inv_ck_onehot", 32'($countones(bus.ck) <= 1), 32'd1);
      chk("inv_stb_within_ck", 32'(bus.stb & ~bus.ck), 32'd0);
      chk("inv_fin_ovr_exclusive", 32'(bus.finished & bus.overrun), 32'd0);
    end
  end

  initial begin
    //            rst  st   hlt  stl  dn   ck         stb        busy fin  ovr
    vecs[0]  = mk(1'b1,1'b0,1'b0,1'b0,1'b0,6'b000000,6'b000000,1'b0,1'b0,1'b0);
    vecs[1]  = mk(1'b0,1'b1,1'b0,1'b0,1'b0,6'b000001,6'b000000,1'b1,1'b0,1'b0);
    vecs[2]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,6'b000001,6'b000001,1'b1,1'b0,1'b0);
    vecs[3]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,6'b000010,6'b000000,1'b1,1'b0,1'b0);
    vecs[4]  = mk(1'b0,1'b0,1'b0,1'b0,1'b1,6'b000000,6'b000000,1'b0,1'b1,1'b0);
    vecs[5]  = mk(1'b0,1'b1,1'b1,1'b0,1'b0,6'b000000,6'b000000,1'b0,1'b0,1'b0);
    vecs[6]  = mk(1'b0,1'b1,1'b0,1'b0,1'b0,6'b000001,6'b000000,1'b1,1'b0,1'b0);
    vecs[7]  = mk(1'b0,1'b1,1'b0,1'b0,1'b0,6'b000001,6'b000001,1'b1,1'b0,1'b0);
    vecs[8]  = mk(1'b0,1'b0,1'b0,1'b1,1'b0,6'b000001,6'b000001,1'b1,1'b0,1'b0);
    vecs[9]  = mk(1'b0,1'b0,1'b0,1'b1,1'b1,6'b000000,6'b000000,1'b0,1'b1,1'b0);
    vecs[10] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,6'b000000,6'b000000,1'b0,1'b0,1'b0);
    vecs[11] = mk(1'b0,1'b1,1'b0,1'b0,1'b0,6'b000001,6'b000000,1'b1,1'b0,1'b0);
    vecs[12] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,6'b000001,6'b000001,1'b1,1'b0,1'b0);
    vecs[13] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,6'b000010,6'b000000,1'b1,1'b0,1'b0);
    vecs[14] = mk(1'b1,1'b1,1'b0,1'b0,1'b0,6'b000000,6'b000000,1'b0,1'b0,1'b0);
    vecs[15] = mk(1'b0,1'b1,1'b0,1'b0,1'b1,6'b000001,6'b000000,1'b1,1'b0,1'b0);
    vecs[16] = mk(1'b0,1'b0,1'b0,1'b0,1'b1,6'b000000,6'b000000,1'b0,1'b1,1'b0);
    vecs[17] = mk(1'b0,1'b1,1'b0,1'b0,1'b0,6'b000001,6'b000000,1'b1,1'b0,1'b0);
    vecs[18] = mk(1'b0,1'b0,1'b0,1'b1,1'b0,6'b000001,6'b000000,1'b1,1'b0,1'b0);
    vecs[19] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,6'b000001,6'b000001,1'b1,1'b0,1'b0);
    vecs[20] = mk(1'b0,1'b0,1'b0,1'b0,1'b1,6'b000000,6'b000000,1'b0,1'b1,1'b0);

    do_reset();
    armed = 1'b1;

    for (int i = 0; i < NV; i++) begin
      reset     = vecs[i].rst;
      bus.start = vecs[i].start;
      bus.halt  = vecs[i].halt;
      bus.stall = vecs[i].stall;
      bus.done  = vecs[i].done;
      tick();
      chk($sformatf("vec%0d", i), outs(),
          pack_exp(vecs[i].ck, vecs[i].stb, vecs[i].busy, vecs[i].fin, vecs[i].ovr));
    end

    // Reset during PHB of step 3 abandons the sequence silently.
    do_reset();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 2; c <= 8; c++) tick();
    chk("rst_seq_phb3", outs(), pack_exp(6'b001000, 6'b001000, 1'b1, 1'b0, 1'b0));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_seq_cleared", outs(), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_seq_quiet", outs(), 32'd0);
    end

    // ISZ-like: done follows ck[4].
    do_reset();
    for (int b = 0; b < N; b++) cnt[b] = 0;
    fin_at = 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      for (int b = 0; b < N; b++) if (bus.stb[b]) cnt[b]++;
      if (bus.finished) begin
        fin_at = c;
        break;
      end
      bus.done = bus.ck[4];
      tick();
    end
    bus.done = 1'b0;
    chk("isz_fin_cycle", 32'(fin_at), 32'd10);
    for (int b = 0; b < N; b++)
      chk($sformatf("isz_stb%0d_count", b), 32'(cnt[b]), (b < 4) ? 32'd1 : 32'd0);

    // Stall through PHB of step 1, then done during a stall.
    do_reset();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    chk("stall_phb1_entry", outs(), pack_exp(6'b000010, 6'b000010, 1'b1, 1'b0, 1'b0));
    hold_cnt = 1;
    bus.stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (bus.stb[1] && bus.ck[1]) hold_cnt++;
    end
    bus.stall = 1'b0;
    tick();
    chk("stall_hold_cycles", 32'(hold_cnt), 32'd4);
    chk("stall_release_pha2", outs(), pack_exp(6'b000100, 6'b000000, 1'b1, 1'b0, 1'b0));
    bus.stall = 1'b1;
    bus.done  = 1'b1;
    tick();
    idle_in();
    chk("stall_done_wins", outs(), pack_exp(6'b000000, 6'b000000, 1'b0, 1'b1, 1'b0));

    // Overrun with done tied low, then back-to-back start in the overrun cycle.
    do_reset();
    busy_cnt = 0;
    ovr_at   = 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (bus.busy) busy_cnt++;
      if (bus.overrun) begin
        ovr_at = c;
        break;
      end
      tick();
    end
    chk("ovr_busy_cycles", 32'(busy_cnt), 32'd12);
    chk("ovr_cycle", 32'(ovr_at), 32'd13);
    chk("ovr_pulse_outs", outs(), pack_exp(6'b000000, 6'b000000, 1'b0, 1'b0, 1'b1));
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("ovr_restart_pha0", outs(), pack_exp(6'b000001, 6'b000000, 1'b1, 1'b0, 1'b0));
    tick();
    chk("ovr_pulse_cleared", 32'(bus.overrun), 32'd0);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;

    // Halt blocks start; halt raised mid-sequence does not abort.
    do_reset();
    bus.halt  = 1'b1;
    bus.start = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("halt_blocks_start", outs(), 32'd0);
    end
    bus.halt = 1'b0;
    tick();
    chk("halt_release_start", outs(), pack_exp(6'b000001, 6'b000000, 1'b1, 1'b0, 1'b0));
    bus.halt = 1'b1;
    fin_at = 0;
    for (int c = 1; c <= 20; c++) begin
      if (bus.finished) begin
        fin_at = c;
        break;
      end
      bus.done = bus.ck[2];
      tick();
    end
    bus.done = 1'b0;
    chk("halt_midseq_fin_cycle", 32'(fin_at), 32'd6);
    tick();
    chk("halt_no_restart", outs(), 32'd0);
    idle_in();
    tick();

    armed = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
